// File: rtl/pc_fetch_ctrl.sv
// Program counter and req/ack instruction-fetch sequencer feeding the PCSrc select.
// Optional misaligned-PC trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl #(
    parameter int unsigned           WIDTH    = 16,
    parameter logic [WIDTH-1:0]      RESET_PC = 16'h0000,
    parameter int unsigned           INC      = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] NextPC,
    input  logic             PCWrite,
    input  logic             Stall,
    input  logic             IMemAck,
    input  logic [WIDTH-1:0] IMemData,
    output logic             IMemReq,
    output logic [WIDTH-1:0] IMemAddr,
    output logic [WIDTH-1:0] Instr,
    output logic             InstrValid,
    output logic [WIDTH-1:0] PC,
`ifdef PC_MISALIGN_TRAP_EN
    output logic             MisalignErr,
`endif
    output logic [WIDTH-1:0] PCPlus2
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_nxt;
    logic   ack_take;
    logic   pc_load;

    assign ack_take = (state == REQ) && IMemAck;
    assign pc_load  = (state == DONE) && PCWrite && !Stall;

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = REQ;
            REQ:     if (IMemAck) state_nxt = DONE;
            DONE:    if (PCWrite && !Stall) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Request and valid are pure state decodes, so they drop on the same edge the state leaves.
    always_comb begin
        IMemReq    = 1'b0;
        InstrValid = 1'b0;
        unique case (state)
            REQ:     IMemReq    = 1'b1;
            DONE:    InstrValid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            PC    <= RESET_PC;
            Instr <= '0;
        end else begin
            if (ack_take) Instr <= IMemData;
`ifdef PC_MISALIGN_TRAP_EN
            if (pc_load) PC <= {NextPC[WIDTH-1:1], 1'b0};
`else
            if (pc_load) PC <= NextPC;
`endif
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge CLK) begin
        if (Reset)                    MisalignErr <= 1'b0;
        else if (pc_load && NextPC[0]) MisalignErr <= 1'b1;
    end
`endif

    assign IMemAddr = PC;
    assign PCPlus2  = PC + WIDTH'(INC);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; covers the trap feature when
// PC_MISALIGN_TRAP_EN is defined.
module tb_pc_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] NextPC;
    logic        PCWrite;
    logic        Stall;
    logic        IMemAck;
    logic [15:0] IMemData;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic [15:0] Instr;
    logic        InstrValid;
    logic [15:0] PC;
    logic [15:0] PCPlus2;
`ifdef PC_MISALIGN_TRAP_EN
    logic        MisalignErr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pc_fetch_ctrl #(.WIDTH(16), .RESET_PC(16'h0000), .INC(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .NextPC     (NextPC),
        .PCWrite    (PCWrite),
        .Stall      (Stall),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
`ifdef PC_MISALIGN_TRAP_EN
        .MisalignErr(MisalignErr),
`endif
        .PCPlus2    (PCPlus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one full cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1; NextPC = '0; PCWrite = 1'b0; Stall = 1'b0;
        IMemAck = 1'b1; IMemData = 16'hDEAD;
        @(negedge CLK);
        tick(); tick();
        check("rst_pc", 32'(PC), 32'h0000);
        check("rst_req", 32'(IMemReq), 0);
        check("rst_valid", 32'(InstrValid), 0);
        check("rst_instr", 32'(Instr), 32'h0000);
`ifdef PC_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(MisalignErr), 0);
`endif

        // Ack held high from the moment reset drops; IDLE must ignore it.
        Reset = 1'b0; IMemData = 16'h1234;
        check("c1_req", 32'(IMemReq), 0);
        tick();
        check("c2_req", 32'(IMemReq), 1);
        check("c2_addr", 32'(IMemAddr), 32'h0000);
        check("c2_valid", 32'(InstrValid), 0);
        tick();
        IMemAck = 1'b0;
        check("f1_instr", 32'(Instr), 32'h1234);
        check("f1_valid", 32'(InstrValid), 1);
        check("f1_req", 32'(IMemReq), 0);
        check("f1_pcp2", 32'(PCPlus2), 32'h0002);

        IMemData = 16'h5555;
        tick();
        check("done_hold_instr", 32'(Instr), 32'h1234);
        check("done_hold_valid", 32'(InstrValid), 1);

        NextPC = 16'h0040; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0; NextPC = 16'h0099;
        check("ld_pc", 32'(PC), 32'h0040);
        check("ld_valid", 32'(InstrValid), 0);
        check("ld_req", 32'(IMemReq), 1);
        check("ld_addr", 32'(IMemAddr), 32'h0040);
        check("ld_pcp2", 32'(PCPlus2), 32'h0042);

        // Ack withheld; PCWrite pulses in REQ must not move the PC.
        for (int i = 0; i < 4; i++) begin
            PCWrite = (i % 2 == 0);
            tick();
            check("wait_req", 32'(IMemReq), 1);
            check("wait_addr", 32'(IMemAddr), 32'h0040);
        end
        PCWrite = 1'b0; IMemAck = 1'b1; IMemData = 16'hBEEF;
        tick();
        IMemAck = 1'b0;
        check("f2_instr", 32'(Instr), 32'hBEEF);
        check("f2_valid", 32'(InstrValid), 1);
        check("f2_pc", 32'(PC), 32'h0040);

        NextPC = 16'h0080; PCWrite = 1'b1; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(PC), 32'h0040);
            check("stall_valid", 32'(InstrValid), 1);
        end
        Stall = 1'b0;
        tick();
        PCWrite = 1'b0;
        check("unstall_pc", 32'(PC), 32'h0080);
        check("unstall_req", 32'(IMemReq), 1);

        IMemAck = 1'b1; IMemData = 16'h0F0F;
        tick();
        IMemAck = 1'b0;
        check("f3_instr", 32'(Instr), 32'h0F0F);

        NextPC = 16'hFFFE; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        check("wrap_pc", 32'(PC), 32'hFFFE);
        check("wrap_pcp2", 32'(PCPlus2), 32'h0000);

        IMemAck = 1'b1;
        tick();
        IMemAck = 1'b0;
        NextPC = 16'h0013; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        check("odd_pc", 32'(PC), 32'h0012);
        check("odd_addr", 32'(IMemAddr), 32'h0012);
        check("odd_err", 32'(MisalignErr), 1);
`else
        check("odd_pc", 32'(PC), 32'h0013);
        check("odd_addr", 32'(IMemAddr), 32'h0013);
`endif
        IMemAck = 1'b1;
        tick();
        IMemAck = 1'b0;
        NextPC = 16'h0020; PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        check("even_pc", 32'(PC), 32'h0020);
`ifdef PC_MISALIGN_TRAP_EN
        check("err_sticky", 32'(MisalignErr), 1);
`endif

        // Now in REQ for 0x0020: abandon it with a reset, then offer a stray ack.
        check("pre_rst_req", 32'(IMemReq), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0; IMemAck = 1'b1;
        check("mrst_req", 32'(IMemReq), 0);
        check("mrst_pc", 32'(PC), 32'h0000);
        check("mrst_valid", 32'(InstrValid), 0);
        check("mrst_instr", 32'(Instr), 32'h0000);
`ifdef PC_MISALIGN_TRAP_EN
        check("mrst_err", 32'(MisalignErr), 0);
`endif
        tick();
        IMemAck = 1'b0;
        check("mrst_stray_valid", 32'(InstrValid), 0);
        check("mrst_rereq", 32'(IMemReq), 1);
        check("mrst_addr", 32'(IMemAddr), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer, directly downstream of the PCSrc 4:1 select.
- Holds the current PC and loads the selected next-PC when control allows.
- Runs a req/ack fetch to instruction memory and returns PC+INC as the sequential candidate on the PCSrc select's input 0.

Parameters:
- WIDTH, 16, address/data width.
- RESET_PC, 16'h0000, PC value after reset.
- INC, 2, sequential PC increment in bytes.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- NextPC  input  WIDTH  selected next PC from the PCSrc select.
- PCWrite  input  1  control request to load NextPC.
- Stall  input  1  hazard stall; blocks the PC load.
- IMemAck  input  1  instruction memory has valid IMemData this cycle.
- IMemData  input  WIDTH  instruction word from memory.
- IMemReq  output  1  fetch request, level-held until acknowledged.
- IMemAddr  output  WIDTH  fetch address; always equals PC.
- Instr  output  WIDTH  latched instruction.
- InstrValid  output  1  Instr is valid for the current PC.
- PC  output  WIDTH  current program counter.
- PCPlus2  output  WIDTH  PC + INC, combinational; goes to the PCSrc select's input 0.

Behaviour:
- Clock and reset: one clock, CLK; Reset is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values: PC=RESET_PC, state=IDLE, IMemReq=0, Instr=0, InstrValid=0. Reset has priority over every other input.
- States: IDLE, REQ, DONE.
- IDLE:
  - Outputs IMemReq=0, InstrValid=0.
  - Unconditional transition to REQ on the next edge. First IMemReq=1 is therefore the 2nd cycle after Reset deasserts.
- REQ:
  - IMemReq=1; IMemAddr=PC, held stable.
  - IMemAck is sampled every cycle in REQ, including the first.
  - On IMemAck=1: Instr<=IMemData, InstrValid<=1, IMemReq<=0, go to DONE.
  - Minimum fetch latency is 1 cycle from IMemReq rising to InstrValid rising.
- DONE:
  - InstrValid=1, IMemReq=0.
  - If PCWrite=1 and Stall=0: PC<=NextPC, InstrValid<=0, go to REQ; the new request is issued the following cycle.
  - Otherwise hold PC, Instr and InstrValid.
- Priority and ignored inputs:
  - Stall has priority over PCWrite.
  - PCWrite is ignored in IDLE and REQ; there is no queuing.
  - IMemAck is ignored outside REQ; a late ack after reset is discarded.
- Arithmetic: PCPlus2 = PC + INC, modulo 2^WIDTH (0xFFFE -> 0x0000). No carry out.
- IMemData is captured only on the ack edge in REQ; changes on IMemData in DONE do not affect Instr.
- Reset mid-fetch: if Reset is asserted while in REQ, IMemReq drops on that edge and the FSM returns to IDLE; the outstanding request is abandoned.
- NextPC is captured only on the load edge; changes on NextPC in other cycles have no effect.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output MisalignErr (1 bit, reset 0).
  - On a PC load with NextPC[0]=1: PC<=NextPC with bit 0 cleared, MisalignErr<=1.
  - MisalignErr is sticky until Reset.
- Undefined:
  - No MisalignErr port.
  - PC<=NextPC unmodified; an odd address is passed straight to IMemAddr.

Test Plan:
- Reset then ack immediately -> cycle 1 IMemReq=0; cycle 2 IMemReq=1, IMemAddr=0x0000; ack with IMemData=0x1234 -> next cycle Instr=0x1234, InstrValid=1, PCPlus2=0x0002.
- DONE, NextPC=0x0040, PCWrite=1, Stall=0 -> PC=0x0040, InstrValid=0; next cycle IMemReq=1, IMemAddr=0x0040; PCPlus2=0x0042.
- DONE, PCWrite=1, Stall=1 for 3 cycles, then Stall=0 -> PC unchanged for 3 cycles; loads NextPC on the edge after Stall falls.
- REQ, IMemAck held low 4 cycles, then high with data 0xBEEF -> IMemReq=1 and IMemAddr stable throughout; Instr=0xBEEF; PCWrite pulses during REQ have no effect.
- Load NextPC=0xFFFE -> PCPlus2=0x0000. Reset asserted during REQ -> IMemReq=0 next cycle, PC=RESET_PC, a stray IMemAck is ignored, InstrValid stays 0.
- PC_MISALIGN_TRAP_EN defined, NextPC=0x0013 loaded -> PC=0x0012, MisalignErr=1 and held; undefined -> PC=0x0013.
